// File: rtl/sram_arb_pkg.sv
// Shared types and bus widths for the SRAM arbiter.
package sram_arb_pkg;

    localparam int SRAM_AW = 21;
    localparam int SRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the single external 8-bit SRAM.
// Port A (CPU/ULA) has priority over port B (loader/DMA). Each access is a
// fixed ACCESS_CYCLES-long SRAM cycle followed by a one-clock ack.
// The board top level owns the inout pin: sram_data = sram_data_oe ? sram_wdata : 'z.
// Optional macro SRAM_ARB_STARVE_GUARD_EN: after MAX_WAIT consecutive A grants
// over a pending B, B is granted once even if A is requesting.
//
//   state  | meaning
//   IDLE   | bus free, arbitrate and latch the winner's request
//   ACCESS | address held, write strobe / read capture over ACCESS_CYCLES clocks
//   DONE   | one-clock ack to the owner, bus released
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_WAIT      = 4
) (
    input  logic               clk28mhz,
    input  logic               reset_n,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [SRAM_AW-1:0] a_addr,
    input  logic [SRAM_DW-1:0] a_wdata,
    output logic [SRAM_DW-1:0] a_rdata,
    output logic               a_ack,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [SRAM_AW-1:0] b_addr,
    input  logic [SRAM_DW-1:0] b_wdata,
    output logic [SRAM_DW-1:0] b_rdata,
    output logic               b_ack,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_data_oe,
    output logic               sram_we_n
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(ACCESS_CYCLES - 2);

    if (ACCESS_CYCLES < 2 || MAX_WAIT < 1) begin : g_bad_param
        $error("sram_arbiter: ACCESS_CYCLES must be >= 2 and MAX_WAIT >= 1");
    end

    state_t             state, state_nxt;
    owner_t             owner, owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               we_r, we_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic [SRAM_DW-1:0] wdata_nxt;
    logic               oe_nxt, we_n_nxt;
    logic               a_ack_nxt, b_ack_nxt;
    logic [SRAM_DW-1:0] a_rdata_nxt, b_rdata_nxt;
    logic               grant_b;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

    logic [WCNT_W-1:0] wcnt, wcnt_nxt;

    assign grant_b = b_req && (!a_req || (wcnt == WCNT_MAX));

    // Count A grants made over a waiting B; clear when B is served or not asking.
    always_comb begin
        wcnt_nxt = wcnt;
        if (state == IDLE) begin
            if (!b_req || grant_b)
                wcnt_nxt = '0;
            else if (wcnt != WCNT_MAX)
                wcnt_nxt = wcnt + WCNT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk28mhz or negedge reset_n) begin
        if (!reset_n) wcnt <= '0;
        else          wcnt <= wcnt_nxt;
    end
`else
    assign grant_b = b_req && !a_req;
`endif

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        we_nxt      = we_r;
        addr_nxt    = sram_addr;
        wdata_nxt   = sram_wdata;
        oe_nxt      = sram_data_oe;
        we_n_nxt    = sram_we_n;
        a_ack_nxt   = 1'b0;
        b_ack_nxt   = 1'b0;
        a_rdata_nxt = a_rdata;
        b_rdata_nxt = b_rdata;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                    if (grant_b) begin
                        owner_nxt = OWN_B;
                        we_nxt    = b_we;
                        addr_nxt  = b_addr;
                        wdata_nxt = b_wdata;
                        oe_nxt    = b_we;
                        we_n_nxt  = !b_we;
                    end else begin
                        owner_nxt = OWN_A;
                        we_nxt    = a_we;
                        addr_nxt  = a_addr;
                        wdata_nxt = a_wdata;
                        oe_nxt    = a_we;
                        we_n_nxt  = !a_we;
                    end
                end
            end
            ACCESS: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Strobe rises one clock early so data is held past the write edge.
                if (cnt == CNT_HOLD)
                    we_n_nxt = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    oe_nxt    = 1'b0;
                    we_n_nxt  = 1'b1;
                    if (owner == OWN_A) begin
                        a_ack_nxt = 1'b1;
                        if (!we_r) a_rdata_nxt = sram_rdata;
                    end else begin
                        b_ack_nxt = 1'b1;
                        if (!we_r) b_rdata_nxt = sram_rdata;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered SRAM/requester outputs; reset aborts any access.
    always_ff @(posedge clk28mhz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            owner        <= OWN_A;
            cnt          <= '0;
            we_r         <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_data_oe <= 1'b0;
            sram_we_n    <= 1'b1;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            cnt          <= cnt_nxt;
            we_r         <= we_nxt;
            sram_addr    <= addr_nxt;
            sram_wdata   <= wdata_nxt;
            sram_data_oe <= oe_nxt;
            sram_we_n    <= we_n_nxt;
            a_ack        <= a_ack_nxt;
            b_ack        <= b_ack_nxt;
            a_rdata      <= a_rdata_nxt;
            b_rdata      <= b_rdata_nxt;
        end
    end

endmodule
